// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Glyphs are active-low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

    typedef logic [0:6] seg7_t;

    localparam seg7_t SEG_OFF = 7'b1111111;

    // b and d use lower-case shapes so they are not confused with 8 and 0
    localparam seg7_t HEX_GLYPHS [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

    localparam logic S_BLANK = 1'b0;
    localparam logic S_ON    = 1'b1;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = HEX_GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed four-digit seven-segment driver with per-slot anode blanking.
// Define SEG7_LZ_BLANK_EN to suppress leading zero digits (digit 3 is always shown).
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:15] i_display_data,
    output logic [0:3]  o_anode,
    output logic [0:6]  o_segments,
    output logic        o_dp,
    output logic        o_frame_start
);

    localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [0:15]   snap_q, snap_d;
    logic          state_q, state_d;
    logic [0:3]    anode_q, anode_d;
    seg7_t         seg_q, seg_d;
    logic          fs_q, fs_d;

    logic          frame_start;
    logic [0:15]   frame_data;
    logic [3:0]    nib;
    seg7_t         glyph;
    logic          lead_zero;

    // cnt_q/idx_q name the position the outputs will show after the next edge
    assign frame_start = (cnt_q == '0) && (idx_q == 2'd0);
    // The new snapshot must already drive the first cycle of digit 0
    assign frame_data  = frame_start ? i_display_data : snap_q;

    always_comb begin
        nib = 4'h0;
        unique case (idx_q)
            2'd0: nib = frame_data[0:3];
            2'd1: nib = frame_data[4:7];
            2'd2: nib = frame_data[8:11];
            2'd3: nib = frame_data[12:15];
            default: nib = 4'h0;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nib),
        .seg    (glyph)
    );

`ifdef SEG7_LZ_BLANK_EN
    always_comb begin
        lead_zero = 1'b0;
        unique case (idx_q)
            2'd0: lead_zero = (frame_data[0:3] == 4'h0);
            2'd1: lead_zero = (frame_data[0:7] == 8'h00);
            2'd2: lead_zero = (frame_data[0:11] == 12'h000);
            2'd3: lead_zero = 1'b0;
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        snap_d  = snap_q;
        state_d = state_q;
        fs_d    = frame_start;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        if (frame_start) begin
            snap_d = i_display_data;
        end
        unique case (state_q)
            S_BLANK: if (cnt_q == CNT_BLANK) state_d = S_ON;
            S_ON:    if (cnt_q == '0)        state_d = S_BLANK;
            default: state_d = S_BLANK;
        endcase
        seg_d = lead_zero ? SEG_OFF : glyph;
    end

    always_comb begin
        anode_d = 4'b1111;
        if (state_d == S_ON) begin
            unique case (idx_q)
                2'd0: anode_d = 4'b0111;
                2'd1: anode_d = 4'b1011;
                2'd2: anode_d = 4'b1101;
                2'd3: anode_d = 4'b1110;
                default: anode_d = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            snap_q  <= '0;
            state_q <= S_BLANK;
            anode_q <= 4'b1111;
            seg_q   <= SEG_OFF;
            fs_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            state_q <= state_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    assign o_anode       = anode_q;
    assign o_segments    = seg_q;
    assign o_dp          = 1'b1;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Honours SEG7_LZ_BLANK_EN when expecting leading-zero blanking.
module tb_seg7_scan;

    localparam int unsigned DC = 8;
    localparam int unsigned BC = 2;

    localparam logic [0:6] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:15] data = 16'h0000;
    logic [0:3]  o_anode;
    logic [0:6]  o_segments;
    logic        o_dp;
    logic        o_frame_start;

    always #5 clk = ~clk;

    seg7_scan #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_display_data (data),
        .o_anode        (o_anode),
        .o_segments     (o_segments),
        .o_dp           (o_dp),
        .o_frame_start  (o_frame_start)
    );

    typedef struct packed {
        logic [0:3]  anode;
        logic [0:6]  seg;
        logic        fs;
        logic        dp;
        logic [15:0] tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] nib_of(input logic [0:15] d, input int idx);
        return {d[idx*4], d[idx*4+1], d[idx*4+2], d[idx*4+3]};
    endfunction

    function automatic logic [0:6] exp_glyph(input logic [0:15] d, input int idx);
        logic lz;
        lz = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        if (idx < 3) begin
            lz = 1'b1;
            for (int j = 0; j <= idx; j++) begin
                if (nib_of(d, j) != 4'h0) lz = 1'b0;
            end
        end
`endif
        return lz ? 7'b1111111 : GLYPH[nib_of(d, idx)];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reset(input logic [15:0] tag);
        exp_t e;
        e.anode = 4'b1111;
        e.seg   = 7'b1111111;
        e.fs    = 1'b0;
        e.dp    = 1'b1;
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic reset_hold(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            rst_n = 1'b0;
            push_reset(16'hFF00 + 16'(i));
        end
        rst_n = 1'b1;
    endtask

    // One frame of expected outputs; optional data change or reset at a given cycle
    task automatic run_frame(input logic [0:15] shown, input int chg_at,
                             input logic [0:15] chg_val, input int abort_at,
                             input logic [7:0] fid);
        exp_t       e;
        logic [0:3] a;
        for (int c = 0; c < 4 * int'(DC); c++) begin
            cycle();
            if (c == abort_at) begin
                rst_n = 1'b0;
                push_reset({fid, 8'(c)});
                return;
            end
            a = 4'b1111;
            if ((c % int'(DC)) >= int'(BC)) a[c / int'(DC)] = 1'b0;
            e.anode = a;
            e.seg   = exp_glyph(shown, c / int'(DC));
            e.fs    = (c == 0);
            e.dp    = 1'b1;
            e.tag   = {fid, 8'(c)};
            q.push_back(e);
            if (c == chg_at) data = chg_val;
        end
    endtask

    // Output monitor: pops one expectation per cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({o_anode, o_segments, o_frame_start, o_dp} !== {e.anode, e.seg, e.fs, e.dp}) begin
                errors++;
                $display("FAIL out[frame %0d cycle %0d]: got anode=%b seg=%b fs=%b dp=%b, expected anode=%b seg=%b fs=%b dp=%b",
                         e.tag[15:8], e.tag[7:0], o_anode, o_segments, o_frame_start, o_dp,
                         e.anode, e.seg, e.fs, e.dp);
            end
        end
    end

    // Anode discipline: one low bit at most, two blank cycles between digits
    int last_pos = -1;
    int blank_run = 0;
    always @(negedge clk) begin
        int pos;
        if (!rst_n) begin
            last_pos  = -1;
            blank_run = 0;
        end else if (o_anode == 4'b1111) begin
            blank_run++;
        end else begin
            checks++;
            if ($countones(~o_anode) != 1) begin
                errors++;
                $display("FAIL anode_onehot: got anode=%b, expected a single low bit", o_anode);
            end else begin
                pos = 0;
                for (int k = 0; k < 4; k++) if (!o_anode[k]) pos = k;
                if (last_pos >= 0 && pos != last_pos) begin
                    checks++;
                    if (blank_run != int'(BC)) begin
                        errors++;
                        $display("FAIL anode_gap: got %0d blank cycles before digit %0d, expected %0d",
                                 blank_run, pos, BC);
                    end
                end
                last_pos  = pos;
                blank_run = 0;
            end
        end
    end

    logic [0:15] frames [7] = '{16'h00E0, 16'h0000, 16'h1234, 16'h0B7D,
                                16'h0000, 16'h9AC6, 16'hFFFF};

    initial begin
        data  = 16'h1234;
        rst_n = 1'b0;
        reset_hold(3);
        run_frame(16'h1234, 11, 16'hFFFF, -1, 8'd1);
        run_frame(16'hFFFF, 31, 16'hA5C9, -1, 8'd2);
        run_frame(16'hA5C9, -1, 16'h0000, 21, 8'd3);
        data = frames[0];
        reset_hold(2);
        for (int i = 0; i < 7; i++) begin
            run_frame(frames[i], 31, (i < 6) ? frames[i+1] : frames[i], -1, 8'(4 + i));
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
